io_bus_event_responder: RTL



---
 rtl/io_bus_event_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/io_bus_event_responder.sv
// IO-bus responder: ID/CTRL/STATUS/SCRATCH registers plus a timestamped
// button-press event FIFO that software drains by reading EVENT.
module io_bus_event_responder #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          DEPTH     = 16,
   parameter int          TS_DIV    = 50000,
   parameter logic [15:0] ID_VALUE  = 16'h4B31
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        button_1_n,
   input  logic        button_2_n,
   input  logic [15:0] io_address,
   input  logic        io_bus_enable,
   input  logic [1:0]  io_byte_enable,
   input  logic        io_rw,
   input  logic [15:0] io_write_data,
   output logic [15:0] io_read_data,
   output logic        io_acknowledge,
   output logic        io_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

   state_t         state_q;
   logic           ack_q;
   logic [15:0]    rdata_q;
   logic           irq_en_q;
   logic [15:0]    scratch_q;
   logic           ovf_q;
   logic           irq_q;
   logic [PW-1:0]  presc_q;
   logic [13:0]    ts_q;
   logic           b1_s1_q, b1_s2_q, b1_s3_q;
   logic           b2_s1_q, b2_s2_q, b2_s3_q;
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   logic [15:0]    mem_q [DEPTH];

   logic           req, hit, wr_hit, rd_hit;
   logic [3:0]     off;
   logic           empty, full;
   logic           press1, press2, push, pop, clr, w1c, do_push, ovf_set;
   logic [15:0]    status, rdata_d;

   // Decode of the request sampled in IDLE
   assign req     = (state_q == S_IDLE) & io_bus_enable;
   assign hit     = (io_address[15:4] == BASE_ADDR[15:4]);
   assign off     = io_address[3:0];
   assign wr_hit  = req & hit & ~io_rw;
   assign rd_hit  = req & hit & io_rw;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign press1  = b1_s3_q & ~b1_s2_q;
   assign press2  = b2_s3_q & ~b2_s2_q;
   assign push    = press1 | press2;
   assign pop     = rd_hit & (off == 4'h6) & ~empty;
   assign clr     = wr_hit & (off == 4'h2) & io_byte_enable[0] & io_write_data[1];
   assign w1c     = wr_hit & (off == 4'h4) & io_byte_enable[1] & io_write_data[8];
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign do_push = push & ~clr & (~full | pop);
   assign ovf_set = push & ~clr & full & ~pop;

   always_comb begin
      status         = '0;
      status[CW-1:0] = count_q;
      status[8]      = ovf_q;
   end

   always_comb begin
      rdata_d = '0;
      if (hit) begin
         case (off)
            4'h0:    rdata_d = ID_VALUE;
            4'h2:    rdata_d = {15'b0, irq_en_q};
            4'h4:    rdata_d = status;
            4'h6:    rdata_d = empty ? 16'h0000 : mem_q[rd_ptr_q];
            4'h8:    rdata_d = scratch_q;
            default: rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (do_push & ~pop)      count_d = count_q + CW'(1);
      else if (~do_push & pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         b1_s1_q <= 1'b1; b1_s2_q <= 1'b1; b1_s3_q <= 1'b1;
         b2_s1_q <= 1'b1; b2_s2_q <= 1'b1; b2_s3_q <= 1'b1;
      end else begin
         b1_s1_q <= button_1_n; b1_s2_q <= b1_s1_q; b1_s3_q <= b1_s2_q;
         b2_s1_q <= button_2_n; b2_s2_q <= b2_s1_q; b2_s3_q <= b2_s2_q;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         presc_q <= '0;
         ts_q    <= '0;
      end else if (presc_q == PW'(TS_DIV - 1)) begin
         presc_q <= '0;
         ts_q    <= ts_q + 14'd1;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {press2, press1, ts_q};
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Set beats a same-cycle write-1-to-clear
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ovf_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (ovf_set)  ovf_q <= 1'b1;
         else if (w1c) ovf_q <= 1'b0;
         irq_q <= irq_en_q & ~empty;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= S_IDLE;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         irq_en_q  <= 1'b0;
         scratch_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (io_bus_enable) begin
                  state_q <= S_ACK;
                  ack_q   <= 1'b1;
                  rdata_q <= io_rw ? rdata_d : 16'h0000;
                  if (wr_hit && off == 4'h2 && io_byte_enable[0])
                     irq_en_q <= io_write_data[0];
                  if (wr_hit && off == 4'h8) begin
                     if (io_byte_enable[0]) scratch_q[7:0]  <= io_write_data[7:0];
                     if (io_byte_enable[1]) scratch_q[15:8] <= io_write_data[15:8];
                  end
               end
            end
            S_ACK: begin
               state_q <= S_WAIT;
               ack_q   <= 1'b0;
               rdata_q <= '0;
            end
            S_WAIT: begin
               if (!io_bus_enable) state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
               rdata_q <= '0;
            end
         endcase
      end
   end

   assign io_read_data   = rdata_q;
   assign io_acknowledge = ack_q;
   assign io_irq         = irq_q;

endmodule
